amdchipkill_encoder: RTL and testbench
======================================

# amdchipkill_encoder

Rank-level RS(10,8) chipkill encoder over GF(2^8): accepts a 64-bit data word and produces the 80-bit codeword consumed by the rank-level RS erasure decoder on the read path. Parity is computed byte-serially, one data symbol per cycle, with Horner accumulation, which keeps area to one constant GF multiplier. It sits on the write path between the memory-controller write buffer and the DRAM data-bus serializer, with valid/ready handshakes on both sides.

## Interface
- No parameters. Field is fixed to primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D) with alpha = 0x02, matching the rank-level decoder.
- clk  input  1  single clock for all state.
- rst  input  1  reset, asynchronous and active-high.
- data_in  input  64  data word; symbol d_i = data_in[63-8i -: 8] (d0 = [63:56], d7 = [7:0]).
- data_valid  input  1  data_in valid.
- data_ready  output  1  encoder can accept a word.
- codeword_out  output  80  codeword {d0..d7, P0, P1}: [79:16] = data_in, [15:8] = P0, [7:0] = P1.
- codeword_valid  output  1  codeword_out valid.
- codeword_ready  input  1  downstream accepts the codeword.
- busy  output  1  high in CALC or DONE.

## Operation
- Parity equations come from H rows [1 … 1 | 1 0] and [1 a … a^7 | 0 1]:
  - P0 = XOR of d0..d7.
  - P1 = XOR over i of a^i·d_i.
- Datapath:
  - data register (64): loaded on accept.
  - acc1 (8): holds P1.
  - acc0 (8): holds P0.
  - cnt (3): byte counter.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1D : 8'h00).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - data_ready = 1 (forced 0 while rst is high).
  - On data_valid && data_ready: capture data_in, clear acc0 and acc1, set cnt = 0, go to CALC.
- CALC, one step per cycle, k = cnt:
  - b = d_(7-k).
  - acc1 <= xtime(acc1) ^ b.
  - acc0 <= acc0 ^ b.
  - cnt <= cnt + 1.
  - After step k = 7, go to DONE. cnt wraps to 0; the wrap is not used.
- DONE:
  - codeword_valid = 1; codeword_out = {data_reg, acc0, acc1}.
  - Hold all values until codeword_ready is sampled high, then go to IDLE.
- Input changes after the accept edge do not affect the codeword in flight. data_valid is ignored outside IDLE.
- codeword_out is zero outside DONE. It is never X.

## Timing
- Reset values:
  - state = IDLE.
  - Data register, acc0, acc1 and cnt = 0.
  - codeword_valid = 0, busy = 0, codeword_out = 0.
  - data_ready = 0 while rst is asserted, and 1 in the first cycle after deassertion.
- Latency: handshake sampled at edge E0. CALC runs for edges E1..E8. codeword_valid is high from the cycle after E8, i.e. 9 cycles from the accept cycle.
- Throughput: at most one word per 10 cycles with codeword_ready tied high (accept, 8 CALC, 1 DONE). No overlap.
- Backpressure: codeword_valid and codeword_out stay stable while codeword_ready = 0. There is no timeout.
- Output handshake at edge F: codeword_valid falls and data_ready rises in the following cycle. A new word can be accepted at edge F+1.
- Reset mid-operation (CALC or DONE): immediate return to reset values. No partial codeword is emitted.
- codeword_ready high in IDLE or CALC has no effect.

## Test plan
- Zero word: data_in = 0 -> codeword_out = 80'h0, valid 9 cycles after accept.
- Single symbols:
  - data_in = 64'h0100_0000_0000_0000 -> codeword 80'h0100_0000_0000_0000_0101.
  - data_in = 64'h0000_0000_0000_0001 -> 80'h0000_0000_0000_0001_0180.
  - data_in = 64'h0080_0000_0000_0000 -> 80'h0080_0000_0000_0000_801D (checks the reduction term).
- Backpressure: hold codeword_ready = 0 for 20 cycles in DONE -> codeword stable, data_ready = 0, data_in changes ignored. Release -> one handshake, then IDLE.
- Back-to-back: 100 random words with codeword_ready = 1. Each codeword must equal the software model and give Decode_result = 2'b00 in the rank-level decoder. Then inject a single-byte error at each location 0..9 -> decoder reports CE at that location and returns the original data.
- Reset in CALC at cnt = 4 -> all outputs at reset values next cycle, no codeword_valid. A following word encodes correctly.
- Reset asserted in DONE while codeword_ready = 1 on the same edge -> no handshake counted, outputs reset.

Source files
------------

// File: rtl/amdchipkill_encoder.sv
// RS(10,8) chipkill encoder over GF(2^8) (poly 0x11D): 64-bit word in, 80-bit codeword {data, P0, P1} out.
// Latency: codeword_valid rises 9 cycles after the accept cycle (8 byte-serial Horner steps, then DONE).
// Backpressure: holds codeword stable in DONE until codeword_ready; data_ready only in IDLE, so no overlap.
module amdchipkill_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [79:0] codeword_out,
    output logic        codeword_valid,
    input  logic        codeword_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] data_reg;
    logic [7:0]  acc0;
    logic [7:0]  acc1;
    logic [2:0]  cnt;
    logic        cw_vld_q;
    logic        busy_q;
    logic [7:0]  sym;

    // Multiply by alpha (0x02) modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // Step k consumes d_(7-k), which sits at data_reg[8k+7:8k]; d7 first so Horner ends on d0.
    always_comb begin
        sym = data_reg[{cnt, 3'b000} +: 8];
    end

    // Encoder FSM with datapath registers and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= 64'h0;
            acc0     <= 8'h0;
            acc1     <= 8'h0;
            cnt      <= 3'd0;
            cw_vld_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        data_reg <= data_in;
                        acc0     <= 8'h0;
                        acc1     <= 8'h0;
                        cnt      <= 3'd0;
                        busy_q   <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc1 <= xtime(acc1) ^ sym;
                    acc0 <= acc0 ^ sym;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        cw_vld_q <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (codeword_ready) begin
                        cw_vld_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    cw_vld_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Output drive: ready only in IDLE and never while reset is held; codeword gated to zero outside DONE.
    always_comb begin
        data_ready     = (state == IDLE) && !rst;
        codeword_valid = cw_vld_q;
        busy           = busy_q;
        codeword_out   = cw_vld_q ? {data_reg, acc0, acc1} : 80'h0;
    end

endmodule

// File: tb/tb_amdchipkill_encoder.sv
// Testbench for amdchipkill_encoder: directed table, backpressure, back-to-back random, reset corners.
// Expected codewords come from hand-computed constants and a direct-sum GF(2^8) model.
// Includes a syndrome-based single-symbol erasure/correction model standing in for the rank decoder.
module tb_amdchipkill_encoder;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [79:0] codeword_out;
    logic        codeword_valid;
    logic        codeword_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int hs    = 0;
    int cyc   = 0;

    amdchipkill_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .codeword_out   (codeword_out),
        .codeword_valid (codeword_valid),
        .codeword_ready (codeword_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (codeword_valid && codeword_ready) hs <= hs + 1;
    end

    typedef struct {
        logic [63:0] d;
        logic [79:0] cw;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_xt(input logic [7:0] x);
        m_xt = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = m_xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] apow(input int e);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < e; k++) r = m_xt(r);
        return r;
    endfunction

    function automatic logic [79:0] model(input logic [63:0] d);
        logic [7:0] p0 = 8'h0;
        logic [7:0] p1 = 8'h0;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            s  = d[63-8*i -: 8];
            p0 = p0 ^ s;
            p1 = p1 ^ gf_mul(apow(i), s);
        end
        return {d, p0, p1};
    endfunction

    // status: 0 = clean, 1 = corrected (loc valid), 2 = uncorrectable
    task automatic decode(input logic [79:0] r, output int status, output int loc,
                          output logic [63:0] dat);
        logic [7:0]  s0 = 8'h0;
        logic [7:0]  s1 = 8'h0;
        logic [79:0] c  = r;
        logic [79:0] m;
        for (int i = 0; i < 8; i++) begin
            s0 = s0 ^ r[79-8*i -: 8];
            s1 = s1 ^ gf_mul(apow(i), r[79-8*i -: 8]);
        end
        s0 = s0 ^ r[15:8];
        s1 = s1 ^ r[7:0];
        status = 2;
        loc    = -1;
        if (s0 == 8'h0 && s1 == 8'h0) begin
            status = 0;
        end else if (s0 == 8'h0) begin
            status = 1; loc = 9; c[7:0] = c[7:0] ^ s1;
        end else if (s1 == 8'h0) begin
            status = 1; loc = 8;
        end else begin
            for (int j = 0; j < 8; j++)
                if (status == 2 && gf_mul(apow(j), s0) == s1) begin
                    status = 1; loc = j;
                end
        end
        if (status == 1 && loc <= 8) begin
            m = {s0, 72'h0};
            m = m >> (8 * loc);
            c = c ^ m;
        end
        dat = c[79:16];
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Offers d, waits for accept and for codeword_valid (bounded).
    // Returns at the negedge where codeword_valid was first seen; lat counts cycles from accept cycle.
    task automatic run_word(input logic [63:0] d, output logic [79:0] cw, output int lat,
                            output int acc_cyc, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!data_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!data_ready) begin
            ok = 1'b0; cw = 80'h0; lat = -1; acc_cyc = -1;
            return;
        end
        data_in    = d;
        data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc    = cyc;
        data_valid = 1'b0;
        data_in    = {$urandom, $urandom};
        n = 0;
        while (!codeword_valid && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = n + 1;
        cw  = codeword_out;
        if (!codeword_valid) ok = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t        vt[8];
        logic [79:0] cw, cw_first, exp;
        logic [63:0] d, dec_dat;
        int          lat, acc_c, prev_acc, bad, hs0, st, loc;
        bit          ok;
        logic [7:0]  e;
        logic [79:0] mask;

        vt[0] = '{64'h0000_0000_0000_0000, 80'h0000_0000_0000_0000_0000};
        vt[1] = '{64'h0100_0000_0000_0000, 80'h0100_0000_0000_0000_0101};
        vt[2] = '{64'h0000_0000_0000_0001, 80'h0000_0000_0000_0001_0180};
        vt[3] = '{64'h0080_0000_0000_0000, 80'h0080_0000_0000_0000_801D};
        vt[4] = '{64'h0101_0101_0101_0101, 80'h0101_0101_0101_0101_00FF};
        vt[5] = '{64'hFF00_0000_0000_0000, 80'hFF00_0000_0000_0000_FFFF};
        vt[6] = '{64'h0000_0000_0000_0002, 80'h0000_0000_0000_0002_021D};
        vt[7] = '{64'h0000_0000_0000_8000, 80'h0000_0000_0000_8000_8087};

        rst            = 1'b1;
        data_in        = 64'h0;
        data_valid     = 1'b0;
        codeword_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_data_ready", {79'h0, data_ready}, 80'h0);
        check("rst_valid", {79'h0, codeword_valid}, 80'h0);
        check("rst_busy", {79'h0, busy}, 80'h0);
        check("rst_cw", codeword_out, 80'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_data_ready", {79'h0, data_ready}, 80'h1);

        // Directed table with codeword_ready tied high
        codeword_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_word(vt[i].d, cw, lat, acc_c, ok);
            check($sformatf("vec%0d_done", i), {79'h0, ok}, 80'h1);
            check($sformatf("vec%0d_cw", i), cw, vt[i].cw);
            check($sformatf("vec%0d_latency", i), 80'(lat), 80'd9);
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                check("post_hs_valid", {79'h0, codeword_valid}, 80'h0);
                check("post_hs_data_ready", {79'h0, data_ready}, 80'h1);
                check("post_hs_cw_zero", codeword_out, 80'h0);
            end
        end

        // Backpressure: 20 cycles of codeword_ready low in DONE
        codeword_ready = 1'b0;
        d = 64'h0123_4567_89AB_CDEF;
        run_word(d, cw, lat, acc_c, ok);
        check("bp_done", {79'h0, ok}, 80'h1);
        check("bp_cw", cw, model(d));
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            data_in    = {$urandom, $urandom};
            data_valid = 1'b1;
            @(negedge clk);
            if (codeword_out !== model(d) || codeword_valid !== 1'b1 ||
                data_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("bp_stable_cycles_bad", 80'(bad), 80'd0);
        data_valid = 1'b0;
        hs0 = hs;
        codeword_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_one_hs", 80'(hs - hs0), 80'd1);
        check("bp_release_valid", {79'h0, codeword_valid}, 80'h0);
        check("bp_release_ready", {79'h0, data_ready}, 80'h1);
        @(negedge clk);
        check("bp_idle_busy", {79'h0, busy}, 80'h0);

        // Back-to-back random words
        bad = 0;
        prev_acc = 0;
        cw_first = 80'h0;
        for (int w = 0; w < 100; w++) begin
            d = {$urandom, $urandom};
            run_word(d, cw, lat, acc_c, ok);
            if (!ok) begin
                check("b2b_timeout", 80'h0, 80'h1);
                break;
            end
            check($sformatf("b2b%0d_cw", w), cw, model(d));
            decode(cw, st, loc, dec_dat);
            check($sformatf("b2b%0d_syndrome", w), 80'(st), 80'd0);
            if (w > 0 && acc_c - prev_acc != 10) bad++;
            prev_acc = acc_c;
            if (w == 99) cw_first = cw;
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_spacing_bad", 80'(bad), 80'd0);

        // Single-symbol error at each location of a DUT codeword
        for (int l = 0; l < 10; l++) begin
            e = 8'($urandom_range(1, 255));
            mask = {e, 72'h0};
            mask = mask >> (8 * l);
            decode(cw_first ^ mask, st, loc, dec_dat);
            check($sformatf("inj%0d_status", l), 80'(st), 80'd1);
            check($sformatf("inj%0d_loc", l), 80'(loc), 80'(l));
            check($sformatf("inj%0d_data", l), {16'h0, dec_dat}, {16'h0, cw_first[79:16]});
        end

        // Reset in CALC at cnt = 4
        codeword_ready = 1'b1;
        data_in    = 64'hDEAD_BEEF_CAFE_F00D;
        data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("calc_busy_before_rst", {79'h0, busy}, 80'h1);
        rst = 1'b1;
        @(negedge clk);
        check("calc_rst_valid", {79'h0, codeword_valid}, 80'h0);
        check("calc_rst_busy", {79'h0, busy}, 80'h0);
        check("calc_rst_cw", codeword_out, 80'h0);
        check("calc_rst_ready", {79'h0, data_ready}, 80'h0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (codeword_valid !== 1'b0) bad++;
        end
        check("calc_rst_no_valid", 80'(bad), 80'd0);
        d = 64'h1122_3344_5566_7788;
        run_word(d, cw, lat, acc_c, ok);
        check("after_calc_rst_cw", cw, model(d));
        @(posedge clk);
        @(negedge clk);

        // Reset in DONE with codeword_ready high on the same edge
        codeword_ready = 1'b0;
        d = 64'hA5A5_5A5A_0F0F_F0F0;
        run_word(d, cw, lat, acc_c, ok);
        exp = model(d);
        check("done_rst_pre_cw", cw, exp);
        hs0 = hs;
        codeword_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_rst_no_hs", 80'(hs - hs0), 80'd0);
        check("done_rst_valid", {79'h0, codeword_valid}, 80'h0);
        check("done_rst_cw", codeword_out, 80'h0);
        check("done_rst_busy", {79'h0, busy}, 80'h0);
        rst = 1'b0;
        @(negedge clk);
        check("done_rst_ready_after", {79'h0, data_ready}, 80'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
